// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
package div_pkg;

    localparam int DIV_NW = 16;
    localparam int DIV_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Counter must hold the value NW itself, hence NW+1.
    function automatic int cnt_width(input int nw);
        return $clog2(nw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW:0] trial;

    // A set top bit would mean the shifted value exceeds any DW-bit divisor.
    always_comb begin
        trial   = {rem_in[DW-1:0], bit_in};
        q_bit   = rem_in[DW] || (trial >= {1'b0, divisor});
        rem_out = q_bit ? (trial - {1'b0, divisor}) : trial;
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_ZERO flag output is built when DIV_ZERO_ERR_EN is defined.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// CALC  | iterating one quotient bit per cycle
// DONE  | out_valid=1, result held until out_ready
module seq_divider_16by8
    import div_pkg::*;
#(
    parameter int NW = DIV_NW,
    parameter int DW = DIV_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] DIVIDEND,
    input  logic [DW-1:0] DIVISOR,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] QUOTIENT,
    output logic [DW-1:0] REMAINDER
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic          DIV_ZERO
`endif
);

    localparam int CW = cnt_width(NW);

    div_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic [DW:0]   rem, rem_next;
    logic [NW-1:0] shift, shift_next;
    logic [DW-1:0] dvsr;
    logic          q_bit;

    div_step #(.DW(DW)) u_step (
        .rem_in  (rem),
        .bit_in  (shift[NW-1]),
        .divisor (dvsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign shift_next = {shift[NW-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            shift     <= '0;
            dvsr      <= '0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
`ifdef DIV_ZERO_ERR_EN
            DIV_ZERO  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift <= DIVIDEND;
                        dvsr  <= DIVISOR;
                        rem   <= '0;
                        cnt   <= CW'(NW);
                        // Zero divisor skips iteration and publishes the result directly.
                        if (DIVISOR == '0) begin
                            QUOTIENT  <= '1;
                            REMAINDER <= DIVIDEND[DW-1:0];
`ifdef DIV_ZERO_ERR_EN
                            DIV_ZERO  <= 1'b1;
`endif
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    shift <= shift_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        QUOTIENT  <= shift_next;
                        REMAINDER <= rem_next[DW-1:0];
                    end
                end
                DONE: begin
`ifdef DIV_ZERO_ERR_EN
                    if (out_ready) DIV_ZERO <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (DIVISOR == '0) ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: scoreboard of expected results, latency and handshake checks.
module tb_seq_divider_16by8;

    localparam int NW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] DIVIDEND;
    logic [DW-1:0] DIVISOR;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] QUOTIENT;
    logic [DW-1:0] REMAINDER;
`ifdef DIV_ZERO_ERR_EN
    logic          DIV_ZERO;
`endif

    always #5 clk = ~clk;

    seq_divider_16by8 #(.NW(NW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .QUOTIENT  (QUOTIENT),
        .REMAINDER (REMAINDER)
`ifdef DIV_ZERO_ERR_EN
        ,
        .DIV_ZERO  (DIV_ZERO)
`endif
    );

    typedef struct {
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [NW-1:0] a, input logic [DW-1:0] b, input int hold);
        exp_t e;
        int   n;
        e.dz  = (b == '0);
        e.q   = e.dz ? '1 : (a / NW'(b));
        e.r   = e.dz ? a[DW-1:0] : DW'(a % NW'(b));
        e.lat = e.dz ? 0 : NW;
        sb.push_back(e);

        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        tick();
        in_valid = 1'b0;
        DIVIDEND = NW'($urandom);
        DIVISOR  = DW'($urandom);

        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk("latency", 32'(n), 32'(e.lat));
        chk("quotient", 32'(QUOTIENT), 32'(e.q));
        chk("remainder", 32'(REMAINDER), 32'(e.r));
`ifdef DIV_ZERO_ERR_EN
        chk("div_zero", 32'(DIV_ZERO), 32'(e.dz));
`endif

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            DIVIDEND = NW'($urandom);
            DIVISOR  = DW'($urandom);
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_quotient", 32'(QUOTIENT), 32'(e.q));
            chk("hold_remainder", 32'(REMAINDER), 32'(e.r));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consumed_out_valid", 32'(out_valid), 32'd0);
        chk("consumed_in_ready", 32'(in_ready), 32'd1);
`ifdef DIV_ZERO_ERR_EN
        chk("consumed_div_zero", 32'(DIV_ZERO), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        DIVIDEND  = '0;
        DIVISOR   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(QUOTIENT), 32'd0);
        chk("rst_remainder", 32'(REMAINDER), 32'd0);
`ifdef DIV_ZERO_ERR_EN
        chk("rst_div_zero", 32'(DIV_ZERO), 32'd0);
`endif

        do_op(16'h1234, 8'h56, 0);
        do_op(16'd96, 8'd13, 5);
        do_op(16'hFFFF, 8'h01, 0);
        do_op(16'h03E8, 8'h00, 2);

        // Abort an operation part-way through iterating.
        in_valid = 1'b1;
        DIVIDEND = 16'h1234;
        DIVISOR  = 8'h56;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        chk("mid_calc_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_quotient", 32'(QUOTIENT), 32'd0);
        chk("abort_remainder", 32'(REMAINDER), 32'd0);

        do_op(16'h00FF, 8'hFF, 0);

        for (int k = 0; k < 8; k++) begin
            do_op(NW'($urandom), DW'($urandom_range(0, 255)), k % 3);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
